// File: rtl/fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_thresh
//  Purpose  : Parametrised single-clock FIFO with occupancy count,
//             programmable almost-full / almost-empty thresholds, sticky
//             overflow / underflow flags and an optional first-word-fall-
//             through read mode.
//  Ports    : clk, rst (sync, active high)
//             wr_en, data_in        - write side
//             rd_en, data_out       - read side (read or pop in FWFT mode)
//             clr_err               - clears the sticky error flags
//             full, empty, almost_full, almost_empty, count
//                                   - status, decoded from registered count
//             overflow, underflow   - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_thresh #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Storage array carries no reset; only pointers and count define validity.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic rd_ok;
  logic wr_ok;

  // Status is decoded from the registered count only, so no request input
  // has a combinational path to any flag.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_ok = rd_en && !empty;
    // A read in the same cycle frees a slot, so a write into a full FIFO
    // is still accepted when paired with an accepted read.
    wr_ok = wr_en && (!full || rd_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting takes priority over a simultaneous clear.
    overflow_d = overflow_q;
    if (wr_en && !wr_ok)  overflow_d = 1'b1;
    else if (clr_err)     overflow_d = 1'b0;

    underflow_d = underflow_q;
    if (rd_en && !rd_ok)  underflow_d = 1'b1;
    else if (clr_err)     underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Writes presented during reset are discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible combinationally; meaningless while empty.
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] data_out_q, data_out_d;

      // Output register only loads on an accepted read; rejected reads hold.
      always_comb begin
        data_out_d = data_out_q;
        if (rd_ok) data_out_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) data_out_q <= '0;
        else     data_out_q <= data_out_d;
      end

      assign data_out = data_out_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_thresh.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_thresh
//  Purpose  : Self-checking bench for fifo_thresh. A standard-mode and a
//             FWFT-mode instance see identical stimulus and are compared
//             every cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_thresh;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;

  logic [WIDTH-1:0] s_data_out, f_data_out;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]       s_count, f_count;

  fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(s_data_out), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_unf;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("std_count",     32'(s_count), 32'(n));
    check("std_full",      32'(s_full),  32'(n == DEPTH));
    check("std_empty",     32'(s_empty), 32'(n == 0));
    check("std_af",        32'(s_af),    32'(n >= 14));
    check("std_ae",        32'(s_ae),    32'(n <= 2));
    check("std_overflow",  32'(s_ovf),   32'(m_ovf));
    check("std_underflow", 32'(s_unf),   32'(m_unf));
    check("std_data_out",  32'(s_data_out), 32'(m_dout));
    check("fwft_count",    32'(f_count), 32'(n));
    check("fwft_empty",    32'(f_empty), 32'(n == 0));
    check("fwft_full",     32'(f_full),  32'(n == DEPTH));
    check("fwft_overflow", 32'(f_ovf),   32'(m_ovf));
    check("fwft_underflow",32'(f_unf),   32'(m_unf));
    if (n > 0) check("fwft_head", 32'(f_data_out), 32'(q[0]));
  endtask

  // One clock: drive at negedge, let the model follow the rules at posedge,
  // then compare shortly after the edge.
  task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] din,
                      input logic clr, input logic rs);
    logic rd_acc, wr_acc;
    @(negedge clk);
    wr_en = wr; rd_en = rd; data_in = din; clr_err = clr; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_acc = rd && (q.size() > 0);
      wr_acc = wr && ((q.size() < DEPTH) || rd_acc);
      if (rd_acc) m_dout = q.pop_front();
      if (wr_acc) q.push_back(din);
      if (wr && !wr_acc) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (rd && !rd_acc) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    wr_en = 0; rd_en = 0; data_in = '0; clr_err = 0; rst = 1;
    m_dout = '0; m_ovf = 0; m_unf = 0;

    // Reset
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);

    // Fill to full
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), 0, 0);

    // Overflow, then clear
    step(1, 0, 8'hA5, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Order and wrap: read 5, write 4, read 15
    for (int i = 0; i < 5; i++)  step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++)  step(1, 0, 8'(8'h11 + i), 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0, 0);

    // Underflow while empty, then simultaneous read/write on empty
    step(0, 1, 8'h00, 0, 0);
    step(1, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 15; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 0);

    // Reset mid-operation with a write pending
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    step(1, 1, 8'hEE, 0, 1);
    step(0, 0, 8'h00, 0, 0);

    // Randomized phases with varying write/read bias
    for (int ph = 0; ph < 4; ph++) begin
      int wp, rp;
      wp = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
      rp = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < rp,
             8'($urandom),
             $urandom_range(0, 99) < 8,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
